gfx_fb_pixel_writer: RTL
========================

Name: gfx_fb_pixel_writer

Overview:
- Accepts a stream of (x, y, colour) pixel writes from a drawing engine.
- Turns them into AXI4 INCR write bursts into the linear framebuffer address space that the stripe interconnect serves.
- Horizontally consecutive pixels are coalesced into one burst. This amortises AXI and SRAM turnaround costs.
- Sits directly upstream of the AXI framebuffer port, alongside the display read path.

Parameters:
- AXI_ADDR_WIDTH, 21: byte address width of the framebuffer AXI port.
- AXI_DATA_WIDTH, 16: data width; exactly one pixel per beat.
- AXI_ID_WIDTH, 6: ID width.
- AXI_ID, 0: constant awid value.
- COLOR_WIDTH, 4: bits per colour channel.
- H_WIDTH, 12: x coordinate width.
- V_WIDTH, 12: y coordinate width.
- H_RES, 640: pixels per line; the framebuffer line stride.
- V_RES, 480: lines.
- MAX_BURST, 16: maximum beats per burst, 1..256.
- IDLE_TIMEOUT, 32: cycles without an accepted pixel before a partial burst is flushed.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- s_pix_valid  input  1  pixel request valid
- s_pix_ready  output  1  pixel accepted when valid && ready
- s_pix_x  input  H_WIDTH  pixel x
- s_pix_y  input  V_WIDTH  pixel y
- s_pix_color  input  3*COLOR_WIDTH  {r,g,b}
- flush  input  1  force issue of any buffered pixels
- busy  output  1  buffer non-empty or transaction outstanding
- err  output  1  sticky: a non-OKAY bresp was seen
- m_axi_awvalid/awready  output/input  1  AW handshake
- m_axi_awaddr  output  AXI_ADDR_WIDTH
- m_axi_awid  output  AXI_ID_WIDTH
- m_axi_awlen  output  8
- m_axi_awsize  output  3
- m_axi_awburst  output  2
- m_axi_wvalid/wready  output/input  1  W handshake
- m_axi_wdata  output  AXI_DATA_WIDTH
- m_axi_wstrb  output  AXI_DATA_WIDTH/8
- m_axi_wlast  output  1
- m_axi_bvalid  input  1
- m_axi_bid  input  AXI_ID_WIDTH  ignored
- m_axi_bresp  input  2
- m_axi_bready  output  1

Behaviour:
- Reset (async, rst=1):
  - State is IDLE; buffer count and timeout counter are 0; err is 0.
  - awvalid, wvalid, wlast and bready are 0; awaddr, awlen and wdata are 0.
  - s_pix_ready=1 once rst deasserts.
  - Reset mid-burst abandons the burst and discards the buffer; no completion is required.
- Address and data rules:
  - Address is (y*H_RES + x) << log2(AXI_DATA_WIDTH/8), truncated to AXI_ADDR_WIDTH.
  - wdata is the colour zero-extended in the LSBs.
  - wstrb is all ones; awsize is log2(AXI_DATA_WIDTH/8); awburst is 2'b01 (INCR); awid is AXI_ID.
- Out-of-range pixels (x>=H_RES or y>=V_RES) are accepted and dropped. They do not break coalescing and do not reset the timeout.
- IDLE:
  - s_pix_ready=1.
  - An accepted in-range pixel sets base_addr and base_y, stores last_x, writes buffer[0], sets count=1, and moves to COLLECT.
  - flush in IDLE is ignored.
- COLLECT, appending a pixel:
  - A pixel is appendable if y==base_y, x==last_x+1, count<MAX_BURST, and the next address's low 12 bits are non-zero (no 4KB crossing).
  - s_pix_ready is combinational: 1 when the presented pixel is appendable, or when s_pix_valid=0.
  - An appended pixel increments count and clears the timeout counter.
- COLLECT, moving to AW (next edge) on any of:
  - a valid non-appendable pixel (ready=0; the pixel stays pending and starts the next burst);
  - count==MAX_BURST;
  - flush=1;
  - the timeout counter reaching IDLE_TIMEOUT-1.
  - If flush and an appendable pixel arrive together, the pixel is appended, then AW follows.
- AW:
  - awvalid=1, awlen=count-1, s_pix_ready=0.
  - awvalid and its fields are held stable until awready; then move to W.
- W:
  - Buffer entries 0..count-1 are emitted in order.
  - The beat index advances on wvalid&&wready.
  - wlast=1 on beat count-1; after that handshake move to B.
  - wvalid may stay high across consecutive beats.
- B:
  - bready=1.
  - On bvalid: if bresp!=2'b00, set err (cleared only by reset); count=0; move to IDLE.
  - Exactly one burst is outstanding at a time.
- busy=1 in every state except IDLE.
- Minimum latency is 1 cycle from the COLLECT exit condition to awvalid.

Decomposition:
- Shared package gfx_fb_pkg:
  - AXI_BURST_INCR=2'b01 and AXI_RESP_OKAY=2'b00;
  - the writer state enum {IDLE, COLLECT, AW, W, B};
  - the 4KB boundary mask constant.
- One sub-module: gfx_fb_burst_buf, a MAX_BURST x AXI_DATA_WIDTH register array with write pointer, read index, clear and count.
- Address multiply and state machine stay in the top.

Test Plan (H_RES=640, 16-bit data, MAX_BURST=16; bench drives awready/wready/bvalid):
- Pixels (10..13, 2), then flush -> one burst: awaddr=2580, awlen=3, 4 beats with wlast on the 4th, bready handshake, then IDLE.
- 17 consecutive pixels x=0..16, y=0 -> burst awaddr=0, awlen=15; then burst awaddr=32, awlen=0 after timeout (32 idle cycles).
- Pixels (5,0) then (7,0) -> s_pix_ready=0 for (7,0) until the first burst completes; bursts at awaddr=10 and 14, each awlen=0.
- Pixels (126,3),(127,3),(128,3) -> index 2047 ends at 4KB: burst awaddr=4092, awlen=1; then awaddr=4096, awlen=0.
- bresp=2'b10 on a burst -> err=1 and stays 1 across later OKAY bursts until rst; rst mid-W -> wvalid=0 immediately, state IDLE.
- awready delayed 5 cycles and wready toggled every other cycle -> awaddr/awlen stable while waiting; wdata order matches input order; no beat lost or duplicated.

Source files
------------

// File: rtl/gfx_fb_pkg.sv
// Shared constants and state encoding for the framebuffer pixel writer.
package gfx_fb_pkg;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [11:0] PAGE_4K_MASK   = 12'hFFF;

    typedef enum logic [2:0] {IDLE, COLLECT, AW, W, B} wr_state_e;
endpackage

// File: rtl/gfx_fb_pixel_writer_if.sv
// Pixel request stream plus AXI4 write channels of the framebuffer port.
interface gfx_fb_pixel_writer_if #(
    parameter int AXI_ADDR_WIDTH = 21,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int COLOR_WIDTH    = 4,
    parameter int H_WIDTH        = 12,
    parameter int V_WIDTH        = 12
);
    logic                        s_pix_valid;
    logic                        s_pix_ready;
    logic [H_WIDTH-1:0]          s_pix_x;
    logic [V_WIDTH-1:0]          s_pix_y;
    logic [3*COLOR_WIDTH-1:0]    s_pix_color;

    logic                        m_axi_awvalid;
    logic                        m_axi_awready;
    logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [AXI_ID_WIDTH-1:0]     m_axi_awid;
    logic [7:0]                  m_axi_awlen;
    logic [2:0]                  m_axi_awsize;
    logic [1:0]                  m_axi_awburst;
    logic                        m_axi_wvalid;
    logic                        m_axi_wready;
    logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                        m_axi_wlast;
    logic                        m_axi_bvalid;
    logic [AXI_ID_WIDTH-1:0]     m_axi_bid;
    logic [1:0]                  m_axi_bresp;
    logic                        m_axi_bready;

    modport master (
        input  s_pix_valid, s_pix_x, s_pix_y, s_pix_color,
        output s_pix_ready,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        input  m_axi_wready,
        input  m_axi_bvalid, m_axi_bid, m_axi_bresp,
        output m_axi_bready
    );

    modport slave (
        output s_pix_valid, s_pix_x, s_pix_y, s_pix_color,
        input  s_pix_ready,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        output m_axi_wready,
        output m_axi_bvalid, m_axi_bid, m_axi_bresp,
        input  m_axi_bready
    );
endinterface

// File: rtl/gfx_fb_burst_buf.sv
// Pixel staging buffer for one burst: append at count, read by beat index.
module gfx_fb_burst_buf #(
    parameter int DEPTH = 16,
    parameter int DW    = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [DW-1:0]    wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [DW-1:0]    rd_data,
    output logic [CNT_W-1:0] count
);
    logic [DEPTH-1:0][DW-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_en && (32'(count) < DEPTH)) begin
            mem[count[IDX_W-1:0]] <= wr_data;
            count                 <= count + CNT_W'(1);
        end
    end

    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/gfx_fb_pixel_writer.sv
// Coalesces horizontally consecutive pixel writes into AXI4 INCR bursts,
// one burst outstanding at a time.
module gfx_fb_pixel_writer
    import gfx_fb_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 21,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ID         = 0,
    parameter int COLOR_WIDTH    = 4,
    parameter int H_WIDTH        = 12,
    parameter int V_WIDTH        = 12,
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int MAX_BURST      = 16,
    parameter int IDLE_TIMEOUT   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    output logic busy,
    output logic err,
    gfx_fb_pixel_writer_if.master bus
);
    localparam int BYTE_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
    localparam int CNT_W      = $clog2(MAX_BURST + 1);
    localparam int IDX_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TMO_W      = $clog2(IDLE_TIMEOUT + 1);

    wr_state_e                 state, state_nxt;
    logic [CNT_W-1:0]          count;
    logic [IDX_W-1:0]          beat;
    logic [TMO_W-1:0]          tmo;
    logic [AXI_ADDR_WIDTH-1:0] base_addr, pix_addr;
    logic [V_WIDTH-1:0]        base_y;
    logic [H_WIDTH-1:0]        last_x;
    logic [31:0]               lin_idx;
    logic [AXI_DATA_WIDTH-1:0] rd_data;
    logic in_range, appendable, pix_keep, w_fire, last_beat, buf_clr, unused_bid;

    assign lin_idx  = 32'(bus.s_pix_y) * 32'(H_RES) + 32'(bus.s_pix_x);
    assign pix_addr = AXI_ADDR_WIDTH'(lin_idx << BYTE_SHIFT);
    assign in_range = (32'(bus.s_pix_x) < 32'(H_RES)) && (32'(bus.s_pix_y) < 32'(V_RES));

    // A zero page offset means this pixel would open a new 4KB page.
    assign appendable = in_range && (bus.s_pix_y == base_y) &&
                        (bus.s_pix_x == last_x + H_WIDTH'(1)) &&
                        (32'(count) < 32'(MAX_BURST)) &&
                        ((pix_addr[11:0] & PAGE_4K_MASK) != '0);

    // Out-of-range pixels are always swallowed while collecting.
    assign bus.s_pix_ready = (state == IDLE) ||
                             (state == COLLECT && (!bus.s_pix_valid || appendable || !in_range));

    assign pix_keep  = bus.s_pix_valid && bus.s_pix_ready && in_range;
    assign w_fire    = bus.m_axi_wvalid && bus.m_axi_wready;
    assign last_beat = (CNT_W'(beat) == count - CNT_W'(1));
    assign buf_clr   = (state == B) && bus.m_axi_bvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        bus.m_axi_awvalid = 1'b0;
        bus.m_axi_wvalid  = 1'b0;
        bus.m_axi_bready  = 1'b0;
        busy              = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.s_pix_valid && in_range) state_nxt = COLLECT;
            end
            COLLECT: begin
                if ((bus.s_pix_valid && in_range && !appendable) ||
                    (count == CNT_W'(MAX_BURST)) || flush ||
                    (tmo == TMO_W'(IDLE_TIMEOUT - 1)))
                    state_nxt = AW;
            end
            AW: begin
                bus.m_axi_awvalid = 1'b1;
                if (bus.m_axi_awready) state_nxt = W;
            end
            W: begin
                bus.m_axi_wvalid = 1'b1;
                if (w_fire && last_beat) state_nxt = B;
            end
            B: begin
                bus.m_axi_bready = 1'b1;
                if (bus.m_axi_bvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_addr <= '0;
            base_y    <= '0;
            last_x    <= '0;
            tmo       <= '0;
            beat      <= '0;
            err       <= 1'b0;
        end else begin
            if (pix_keep) begin
                last_x <= bus.s_pix_x;
                if (state == IDLE) begin
                    base_addr <= pix_addr;
                    base_y    <= bus.s_pix_y;
                end
            end
            if (state == COLLECT && !pix_keep) tmo <= tmo + TMO_W'(1);
            else                               tmo <= '0;
            if (w_fire) beat <= last_beat ? '0 : beat + IDX_W'(1);
            if (buf_clr && bus.m_axi_bresp != AXI_RESP_OKAY) err <= 1'b1;
        end
    end

    gfx_fb_burst_buf #(.DEPTH(MAX_BURST), .DW(AXI_DATA_WIDTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (pix_keep),
        .wr_data (AXI_DATA_WIDTH'(bus.s_pix_color)),
        .rd_idx  (beat),
        .rd_data (rd_data),
        .count   (count)
    );

    assign bus.m_axi_awaddr  = base_addr;
    assign bus.m_axi_awlen   = bus.m_axi_awvalid ? 8'(count - CNT_W'(1)) : 8'd0;
    assign bus.m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
    assign bus.m_axi_awsize  = 3'(BYTE_SHIFT);
    assign bus.m_axi_awburst = AXI_BURST_INCR;
    assign bus.m_axi_wdata   = rd_data;
    assign bus.m_axi_wstrb   = '1;
    assign bus.m_axi_wlast   = bus.m_axi_wvalid && last_beat;
    assign unused_bid        = ^bus.m_axi_bid;
endmodule
